// File: rtl/fetch_stage.sv
// fetch_stage: owns the pc, fetches words over req/gnt/rvalid, hands them to decode, applies redirects
module fetch_stage #(
  parameter int N = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic         if_valid,
  output logic [N-1:0] if_pc,
  output logic [31:0]  if_instr,
  input  logic         if_ready,
  output logic [31:0]  fetch_count
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;
  state_t state, state_n;
  logic live, kill, kill_n, take, leave;
  logic [N-1:0] pc;
  assign imem_req = live && state == S_REQ;
  assign imem_addr = pc;
  assign take = state == S_WAIT && imem_rvalid && !kill && !branch_taken;
  assign leave = state == S_OUT && (if_ready || branch_taken);
  always_comb begin
    state_n = imem_req && imem_gnt ? S_WAIT :
              state == S_WAIT && imem_rvalid ? (take ? S_OUT : S_REQ) :
              leave ? S_REQ : state;
    kill_n = imem_req && imem_gnt ? branch_taken :
             state == S_WAIT ? (imem_rvalid ? 1'b0 : kill || branch_taken) : kill;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_REQ;
      live <= 1'b0;
      kill <= 1'b0;
      pc <= RESET_PC;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_instr <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      live <= 1'b1;
      kill <= kill_n;
      pc <= branch_taken ? branch_target & ~N'(3) : take ? pc + N'(4) : pc;
      if_valid <= take ? 1'b1 : leave ? 1'b0 : if_valid;
      if_pc <= take ? pc : if_pc;
      if_instr <= take ? imem_rdata : if_instr;
      fetch_count <= state == S_OUT && if_ready ? fetch_count + 32'd1 : fetch_count;
    end
  end
endmodule
